// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - core/LU/register-file write-port bundle
// The master side drives core and LU requests; the slave side is the arbiter.
interface regfile_wb_arbiter_if;
  logic        core_wen;
  logic [4:0]  core_rd;
  logic [31:0] core_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        core_stall;
  logic        RegWEn;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        sb_error;

  modport master (
    output core_wen, core_rd, core_data, rs1_addr, rs2_addr,
    output lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
    input  lu_ready, core_stall, RegWEn, rd_addr, rd_data, sb_error
  );

  modport slave (
    input  core_wen, core_rd, core_data, rs1_addr, rs2_addr,
    input  lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
    output lu_ready, core_stall, RegWEn, rd_addr, rd_data, sb_error
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between core writeback and a long-latency unit
// LU results queue in a 2-entry FIFO, drain into idle port cycles, and are tracked by a pending scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_arbiter_if.slave bus
);

  logic [1:0]  count;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [4:0]  tail_rd;
  logic [31:0] tail_data;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic [3:0]  age;
  logic        stall_q;
  logic        error_q;
  logic        error_set;
  logic        push;
  logic        pop;
  logic        core_own;
  logic        stall;

  assign bus.lu_ready = (count != 2'd2);
  assign push         = bus.lu_valid & bus.lu_ready;
  assign core_own     = bus.core_wen & (bus.core_rd != 5'd0);
  assign pop          = ~core_own & (count != 2'd0);

  // A write to x0 is a no-op, so it leaves the port free for the FIFO head.
  always_comb begin
    bus.RegWEn  = 1'b0;
    bus.rd_addr = 5'd0;
    bus.rd_data = 32'd0;
    if (core_own) begin
      bus.RegWEn  = 1'b1;
      bus.rd_addr = bus.core_rd;
      bus.rd_data = bus.core_data;
    end else if (pop) begin
      bus.RegWEn  = 1'b1;
      bus.rd_addr = head_rd;
      bus.rd_data = head_data;
    end
  end

  // pending[0] is held clear, so x0 never contributes to a stall.
  assign stall = pending[bus.rs1_addr]
               | pending[bus.rs2_addr]
               | (bus.core_wen & pending[bus.core_rd])
               | (age >= 4'(STARVE_LIMIT));
  assign bus.core_stall = stall;
  assign bus.sb_error   = error_q;

  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[head_rd] = 1'b0;
    if (bus.lu_issue && bus.lu_issue_rd != 5'd0)
      pending_next[bus.lu_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    error_set = 1'b0;
    if (push && bus.lu_rd != 5'd0 && !pending[bus.lu_rd])
      error_set = 1'b1;
    if (bus.lu_issue && pending[bus.lu_issue_rd])
      error_set = 1'b1;
    if (bus.core_wen && stall_q)
      error_set = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head_rd   <= 5'd0;
      head_data <= 32'd0;
      tail_rd   <= 5'd0;
      tail_data <= 32'd0;
      pending   <= 32'd0;
      age       <= 4'd0;
      stall_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_rd   <= bus.lu_rd;
            head_data <= bus.lu_data;
          end else begin
            tail_rd   <= bus.lu_rd;
            tail_data <= bus.lu_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_rd   <= tail_rd;
          head_data <= tail_data;
          count     <= count - 2'd1;
        end
        // Push with pop only happens at count 1: the new entry becomes the head.
        2'b11: begin
          head_rd   <= bus.lu_rd;
          head_data <= bus.lu_data;
        end
        default: ;
      endcase

      if (count == 2'd0 || pop)
        age <= 4'd0;
      else if (age != 4'hF)
        age <= age + 4'd1;

      pending <= pending_next;
      stall_q <= stall;
      if (error_set)
        error_q <= 1'b1;
    end
  end

endmodule
